scmp_bus_arb: RTL and testbench

Round-robin arbiter that shares one SC/MP external bus (addr, D, ADS_n/RD_n/WR_n) between NREQ bus masters: scmp cores or DMA engines. It implements the BREQ/ENIN/ENOUT role in a single registered block. It enforces a turnaround gap between owners to prevent tri-state D contention, and a hold watchdog that forcibly revokes a grant from a stuck master. It sits at top level, between the masters' request lines and the external bus mux select.

---
 rtl/scmp_arb_pak.sv | 15 +
 rtl/scmp_rr_pick.sv | 37 +++
 rtl/scmp_bus_arb.sv | 150 +++++++++++++++
 tb/tb_scmp_bus_arb.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scmp_arb_pak.sv
// Shared types and sizing helpers for the SC/MP external bus arbiter.
package scmp_arb_pak;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } ARB_STATE_t;

    // Owner index width; never below one bit so a single-master build still has a port.
    function automatic int unsigned arb_ow(input int unsigned nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/scmp_rr_pick.sv
// Combinational round-robin picker: first set bit of elig at or above ptr, wrapping.
module scmp_rr_pick
    import scmp_arb_pak::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned OW   = arb_ow(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [OW-1:0]   ptr,
    output logic            valid,
    output logic [OW-1:0]   idx,
    output logic [NREQ-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Upper segment [ptr, NREQ) first, then the wrapped segment [0, ptr).
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!valid && elig[i] && (i >= 32'(ptr))) begin
                valid = 1'b1;
                idx   = OW'(i);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!valid && elig[i]) begin
                valid = 1'b1;
                idx   = OW'(i);
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/scmp_bus_arb.sv
// Round-robin owner arbiter for the shared SC/MP external bus, with a turnaround gap
// between owners and a hold watchdog that revokes a stuck master.
module scmp_bus_arb
    import scmp_arb_pak::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MAX_HOLD    = 255,
    parameter int unsigned TURN_CYCLES = 1,
    localparam int unsigned OW         = arb_ow(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            hold_n,
    output logic [NREQ-1:0] gnt,
    output logic            bus_busy,
    output logic [OW-1:0]   owner,
    output logic            timeout,
    output logic [OW-1:0]   timeout_id
);

    localparam int unsigned HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [3:0]    TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [OW-1:0] PTR_LAST  = OW'(NREQ - 1);

    ARB_STATE_t      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            timeout_q, timeout_d;
    logic [OW-1:0]   tid_q, tid_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] mask_q, mask_d;
    logic [NREQ-1:0] mask_set;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]      turn_cnt_q, turn_cnt_d;

    logic [NREQ-1:0] elig;
    logic            pick_valid;
    logic [OW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_onehot;

    assign elig = req & ~mask_q;

    scmp_rr_pick #(
        .NREQ (NREQ),
        .OW   (OW)
    ) u_pick (
        .elig   (elig),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        tid_d      = tid_q;
        rr_ptr_d   = rr_ptr_q;
        mask_set   = '0;
        hold_cnt_d = hold_cnt_q;
        turn_cnt_d = turn_cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    gnt_d      = pick_onehot;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                // >= so an expiry deferred by hold_n still fires once hold_n rises.
                if (hold_n && (!req[owner_q] ||
                               ((MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LAST)))) begin
                    gnt_d      = '0;
                    turn_cnt_d = '0;
                    state_d    = ARB_TURN;
                    rr_ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
                    if (req[owner_q]) begin
                        mask_set[owner_q] = 1'b1;
                        timeout_d         = 1'b1;
                        tid_d             = owner_q;
                    end
                end
            end
            ARB_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    if (pick_valid) begin
                        gnt_d      = pick_onehot;
                        owner_d    = pick_idx;
                        hold_cnt_d = '0;
                        state_d    = ARB_GRANT;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // A revoked master stays masked only while it keeps req asserted.
        mask_d = (mask_q | mask_set) & req;
        busy_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            timeout_q  <= 1'b0;
            tid_q      <= '0;
            rr_ptr_q   <= '0;
            mask_q     <= '0;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            tid_q      <= tid_d;
            rr_ptr_q   <= rr_ptr_d;
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    assign gnt        = gnt_q;
    assign bus_busy   = busy_q;
    assign owner      = owner_q;
    assign timeout    = timeout_q;
    assign timeout_id = tid_q;

endmodule

// File: tb/tb_scmp_bus_arb.sv
// Scoreboarded bench for scmp_bus_arb: MAX_HOLD=8 main instance, MAX_HOLD=4 side instance.
module tb_scmp_bus_arb;

    typedef struct packed {
        logic [3:0] req;
        logic       hn;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       to;
        logic [1:0] tid;
    } row_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       hold_n;

    logic [3:0] gnt, gnt4;
    logic       bus_busy, bus_busy4;
    logic [1:0] owner, owner4;
    logic       timeout, timeout4;
    logic [1:0] timeout_id, timeout_id4;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q[$];

    scmp_bus_arb #(
        .NREQ        (4),
        .MAX_HOLD    (8),
        .TURN_CYCLES (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .hold_n     (hold_n),
        .gnt        (gnt),
        .bus_busy   (bus_busy),
        .owner      (owner),
        .timeout    (timeout),
        .timeout_id (timeout_id)
    );

    scmp_bus_arb #(
        .NREQ        (4),
        .MAX_HOLD    (4),
        .TURN_CYCLES (1)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .hold_n     (hold_n),
        .gnt        (gnt4),
        .bus_busy   (bus_busy4),
        .owner      (owner4),
        .timeout    (timeout4),
        .timeout_id (timeout_id4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {gnt, bus_busy, owner, timeout, timeout_id}; bus_busy is |gnt by definition.
    function automatic logic [9:0] expv(input row_t r);
        return {r.gnt, |r.gnt, r.own, r.to, r.tid};
    endfunction

    task automatic apply_reset();
        rst_n  = 1'b0;
        req    = 4'b0000;
        hold_n = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n  = 1'b0;
        req    = 4'b1111;
        hold_n = 1'b1;
        exp_q.push_back(10'b0);
        exp_q.push_back(10'b0);
        @(posedge clk);
        #1;
        got = {gnt, bus_busy, owner, timeout, timeout_id};
        checks++;
        if (got !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL reset_main got=%b want=%b", got, 10'b0);
        end
        got = {gnt4, bus_busy4, owner4, timeout4, timeout_id4};
        checks++;
        if (got !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL reset_side got=%b want=%b", got, 10'b0);
        end
        apply_reset();
    endtask

    task automatic test_single();
        row_t rows [4];
        logic [9:0] got, want;
        rows = '{'{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0}};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL single[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    // Each owner keeps the bus 3 cycles, drops for one cycle, then competes again.
    task automatic test_contention();
        row_t r;
        logic [3:0] oh;
        logic [9:0] got, want;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            for (int p = 0; p < 4; p++) begin
                r.req = (p == 3) ? (4'b1111 & ~oh) : 4'b1111;
                r.hn  = 1'b1;
                r.gnt = (p == 3) ? 4'b0000 : oh;
                r.own = 2'(k % 4);
                r.to  = 1'b0;
                r.tid = 2'd0;
                req    = r.req;
                hold_n = r.hn;
                exp_q.push_back(expv(r));
                @(posedge clk);
                #1;
                want = exp_q.pop_front();
                got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL contention[%0d.%0d] got=%b want=%b", k, p, got, want);
                end
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows [6];
        logic [9:0] got, want;
        rows = '{'{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd0},
                 '{4'b1000, 1'b1, 4'b1000, 2'd3, 1'b0, 2'd0},
                 '{4'b0001, 1'b1, 4'b0000, 2'd3, 1'b0, 2'd0},
                 '{4'b1001, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0}};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    task automatic test_watchdog();
        row_t rows [16];
        logic [9:0] got, want;
        rows = '{'{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0101, 1'b1, 4'b0000, 2'd2, 1'b1, 2'd2},
                 '{4'b0101, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 2'd0}};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL watchdog[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    // Owner 1 drops req under hold_n=0; the grant must survive until hold_n rises.
    task automatic test_hold();
        row_t rows [9];
        logic [9:0] got, want;
        rows = '{'{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd0}};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL hold[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    // MAX_HOLD=4 instance: expiry is deferred while hold_n=0 and fires on the first high edge.
    task automatic test_hold_expiry();
        row_t rows [10];
        logic [9:0] got, want;
        rows = '{'{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1, 2'd0},
                 '{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 2'd0},
                 '{4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0}};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt4, bus_busy4, owner4, timeout4, want[2] ? timeout_id4 : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL hold_expiry[%0d] got=%b want=%b", i, got, want);
            end
        end
    endtask

    // Move rr_ptr to 2, reset during owner 2's tenure, then expect master 0 to win first.
    task automatic test_reset_mid();
        row_t rows [4];
        row_t last;
        logic [9:0] got, want;
        rows = '{'{4'b0010, 1'b1, 4'b0010, 2'd1, 1'b0, 2'd0},
                 '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0},
                 '{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0, 2'd0}};
        last = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0, 2'd0};
        apply_reset();
        foreach (rows[i]) begin
            req    = rows[i].req;
            hold_n = rows[i].hn;
            exp_q.push_back(expv(rows[i]));
            @(posedge clk);
            #1;
            want = exp_q.pop_front();
            got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid[%0d] got=%b want=%b", i, got, want);
            end
        end
        #2 rst_n = 1'b0;
        exp_q.push_back(10'b0);
        #1;
        want = exp_q.pop_front();
        got  = {gnt, bus_busy, owner, timeout, timeout_id};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", got, want);
        end
        req = last.req;
        hold_n = last.hn;
        #3 rst_n = 1'b1;
        exp_q.push_back(expv(last));
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        got  = {gnt, bus_busy, owner, timeout, want[2] ? timeout_id : 2'b00};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL reset_first_grant got=%b want=%b", got, want);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 4'b0000;
        hold_n = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_watchdog();
        test_hold();
        test_hold_expiry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim time exceeded, checks=%0d", checks);
        $fatal(1, "bench did not complete");
    end

endmodule
